// File: rtl/rom_boot_copier.sv
// Boot-time copier: streams LENGTH bytes from a 1-cycle-latency ROM read port
// into the RAM write port at one byte per cycle, then raises done.
module rom_boot_copier #(
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int LENGTH         = 256,
  parameter int RAM_BASE       = 0,
  parameter bit AUTO_START     = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic                      rom_rd,
  input  logic [7:0]                rom_data,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                ram_data,
  output logic                      ram_wr,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, COPY, FLUSH, DONE} state_t;

  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_ADDR = ROM_ADDR_WIDTH'(LENGTH - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] BASE_ADDR = RAM_ADDR_WIDTH'(RAM_BASE);

  state_t                      state_reg, state_next;
  logic [ROM_ADDR_WIDTH-1:0]   rom_addr_reg, rom_addr_next;
  logic                        rom_rd_reg, rom_rd_next;
  logic [RAM_ADDR_WIDTH-1:0]   ram_addr_reg, ram_addr_next;
  logic                        ram_wr_reg, ram_wr_next;
  logic                        busy_reg, busy_next;
  logic                        done_reg, done_next;
  // Armed by reset so the first edge after release can launch a copy on its own.
  logic                        auto_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rom_addr_reg <= '0;
      rom_rd_reg   <= 1'b0;
      ram_addr_reg <= BASE_ADDR;
      ram_wr_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      auto_reg     <= AUTO_START;
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      rom_rd_reg   <= rom_rd_next;
      ram_addr_reg <= ram_addr_next;
      ram_wr_reg   <= ram_wr_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      auto_reg     <= 1'b0;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rom_addr_next = rom_addr_reg;
    rom_rd_next   = rom_rd_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    // Write side trails the read side by exactly the ROM latency.
    ram_wr_next   = rom_rd_reg;
    ram_addr_next = ram_wr_reg ? ram_addr_reg + 1'b1 : ram_addr_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start || auto_reg) begin
          state_next    = COPY;
          rom_addr_next = '0;
          rom_rd_next   = 1'b1;
          busy_next     = 1'b1;
          done_next     = 1'b0;
          ram_addr_next = BASE_ADDR;
        end
      end
      COPY: begin
        // Stop at LAST_ADDR so a full-ROM copy never wraps back to address 0.
        if (rom_addr_reg < LAST_ADDR) begin
          rom_addr_next = rom_addr_reg + 1'b1;
        end else begin
          rom_rd_next = 1'b0;
          state_next  = FLUSH;
        end
      end
      FLUSH: begin
        state_next = DONE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rom_addr = rom_addr_reg;
  assign rom_rd   = rom_rd_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_data = rom_data;
  assign ram_wr   = ram_wr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_rom_boot_copier.sv
// Scoreboard bench for rom_boot_copier: three instances (auto-start, full-ROM
// manual with wrapping RAM base, single-byte) checked against expected-write queues.
module tb_rom_boot_copier;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_v    [3];
  logic [7:0] rom_addr_v [3];
  logic       rom_rd_v   [3];
  logic [7:0] rom_data_v [3];
  logic [9:0] ram_addr_v [3];
  logic [7:0] ram_data_v [3];
  logic       ram_wr_v   [3];
  logic       busy_v     [3];
  logic       done_v     [3];

  int         base_v [3] = '{0, 'h3F8, 5};

  // Scoreboard: stimulus appends expected {ram_addr, data}; monitor walks wr_idx.
  logic [17:0] exp_mem [3][2048];
  int          exp_n     [3] = '{0, 0, 0};
  int          wr_idx    [3] = '{0, 0, 0};
  logic        prev_rd   [3] = '{1'b0, 1'b0, 1'b0};
  int          last_a    [3] = '{0, 0, 0};
  int          rd_cnt    [3] = '{0, 0, 0};
  int          burst_len [3] = '{0, 0, 0};

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rom_boot_copier #(.ROM_ADDR_WIDTH(8), .RAM_ADDR_WIDTH(10), .LENGTH(16),
                    .RAM_BASE(0), .AUTO_START(1'b1)) u_auto (
    .clk(clk), .reset(reset), .start(start_v[0]), .rom_addr(rom_addr_v[0]),
    .rom_rd(rom_rd_v[0]), .rom_data(rom_data_v[0]), .ram_addr(ram_addr_v[0]),
    .ram_data(ram_data_v[0]), .ram_wr(ram_wr_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  rom_boot_copier #(.ROM_ADDR_WIDTH(8), .RAM_ADDR_WIDTH(10), .LENGTH(256),
                    .RAM_BASE('h3F8), .AUTO_START(1'b0)) u_full (
    .clk(clk), .reset(reset), .start(start_v[1]), .rom_addr(rom_addr_v[1]),
    .rom_rd(rom_rd_v[1]), .rom_data(rom_data_v[1]), .ram_addr(ram_addr_v[1]),
    .ram_data(ram_data_v[1]), .ram_wr(ram_wr_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  rom_boot_copier #(.ROM_ADDR_WIDTH(8), .RAM_ADDR_WIDTH(10), .LENGTH(1),
                    .RAM_BASE(5), .AUTO_START(1'b0)) u_one (
    .clk(clk), .reset(reset), .start(start_v[2]), .rom_addr(rom_addr_v[2]),
    .rom_rd(rom_rd_v[2]), .rom_data(rom_data_v[2]), .ram_addr(ram_addr_v[2]),
    .ram_data(ram_data_v[2]), .ram_wr(ram_wr_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // ROM model: ROM[i] = i ^ A5, synchronous read with one cycle of latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (rom_rd_v[i]) rom_data_v[i] <= rom_addr_v[i] ^ 8'hA5;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input int len);
    for (int k = 0; k < len; k++) begin
      exp_mem[sel][exp_n[sel]] = {10'((base_v[sel] + k) % 1024), 8'(k) ^ 8'hA5};
      exp_n[sel]++;
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_rom_addr"}, int'(rom_addr_v[sel]), 0);
    check({tag, "_rom_rd"},   int'(rom_rd_v[sel]), 0);
    check({tag, "_ram_addr"}, int'(ram_addr_v[sel]), base_v[sel]);
    check({tag, "_ram_wr"},   int'(ram_wr_v[sel]), 0);
    check({tag, "_busy"},     int'(busy_v[sel]), 0);
    check({tag, "_done"},     int'(done_v[sel]), 0);
  endtask

  task automatic monitor_one(input int i);
    int exp_a;
    if (reset) begin
      wr_idx[i]  = exp_n[i];
      prev_rd[i] = 1'b0;
      rd_cnt[i]  = 0;
      return;
    end
    if (ram_wr_v[i]) begin
      check("write_expected", int'(wr_idx[i] < exp_n[i]), 1);
      if (wr_idx[i] < exp_n[i]) begin
        check("ram_write", int'({ram_addr_v[i], ram_data_v[i]}), int'(exp_mem[i][wr_idx[i]]));
        wr_idx[i]++;
      end
      check("wr_busy", int'(busy_v[i]), 1);
    end
    if (rom_rd_v[i]) begin
      exp_a = prev_rd[i] ? last_a[i] + 1 : 0;
      check("rom_addr_seq", int'(rom_addr_v[i]), exp_a);
      last_a[i] = exp_a;
      rd_cnt[i] = prev_rd[i] ? rd_cnt[i] + 1 : 1;
    end else if (prev_rd[i]) begin
      burst_len[i] = rd_cnt[i];
    end
    prev_rd[i] = rom_rd_v[i];
  endtask

  // Issues a start pulse (optionally a second ignored pulse while busy) and times it.
  task automatic run_copy(input int sel, input int len, input int ignore_at);
    int  lat = 0;
    int  busy_n = 0;
    bit  seen_done = 1'b0;
    push(sel, len);
    start_v[sel] = 1'b1;
    while (!seen_done && lat < len + 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start_v[sel] = 1'b0;
        check("done_drop", int'(done_v[sel]), 0);
      end
      if (ignore_at != 0 && lat == ignore_at)     start_v[sel] = 1'b1;
      if (ignore_at != 0 && lat == ignore_at + 1) start_v[sel] = 1'b0;
      if (busy_v[sel]) busy_n++;
      seen_done = done_v[sel];
    end
    check("latency", lat, len + 2);
    check("busy_cycles", busy_n, len + 1);
    check("writes_consumed", wr_idx[sel], exp_n[sel]);
    check("read_burst", burst_len[sel], len);
    $display("copy inst=%0d len=%0d latency=%0d busy_cycles=%0d writes=%0d",
             sel, len, lat, busy_n, wr_idx[sel]);
  endtask

  initial begin
    int c;
    int busy_n;
    int done_at;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) monitor_one(i);
      end
    join_none

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "reset");

    // Auto start on the first edge after release.
    @(posedge clk);
    #2;
    push(0, 16);
    reset = 1'b0;
    c = 0; busy_n = 0; done_at = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (busy_v[0]) busy_n++;
      if (done_v[0] && done_at == 0) done_at = c;
    end
    check("auto_done_cycle", done_at, 18);
    check("auto_busy_cycles", busy_n, 17);
    check("auto_done_held", int'(done_v[0]), 1);
    check("auto_writes", wr_idx[0], exp_n[0]);
    check("auto_reads", burst_len[0], 16);
    check("full_stays_idle", int'(busy_v[1]), 0);
    check("one_stays_idle", int'(done_v[2]), 0);
    $display("copy inst=0 len=16 done_cycle=%0d busy_cycles=%0d writes=%0d", done_at, busy_n, wr_idx[0]);

    // Full ROM into a wrapping RAM window, start pulsed again while busy; then restart from DONE.
    run_copy(1, 256, 4);
    run_copy(1, 256, 0);
    run_copy(2, 1, 0);

    // Asynchronous reset in the middle of a copy.
    push(1, 16);
    start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midcopy_busy", int'(busy_v[1]), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check_idle(i, "async_reset");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    push(0, 16);
    reset = 1'b0;
    repeat (24) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("post_reset_full_busy", int'(busy_v[1]), 0);
    check("post_reset_full_done", int'(done_v[1]), 0);
    check("post_reset_full_writes", wr_idx[1], exp_n[1]);
    check("post_reset_auto_done", int'(done_v[0]), 1);
    check("post_reset_auto_writes", wr_idx[0], exp_n[0]);
    $display("reset recovery: full idle busy=%0d, auto writes=%0d", busy_v[1], wr_idx[0]);

    run_copy(1, 256, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
